// File: rtl/alu_result_scanner.sv
// Shows a captured ALU result {OF, ZF, F} on eight LEDs, one byte at a time.
// The byte changes every DWELL_CYCLES clocks. A hold switch freezes the display on the current byte.
module alu_result_scanner #(
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic        ALU_RESULT_SCANNER_clk_xi,
    input  logic        ALU_RESULT_SCANNER_rst_n_xi,
    input  logic [31:0] ALU_RESULT_SCANNER_data_xi,
    input  logic        ALU_RESULT_SCANNER_overflow_flag_xi,
    input  logic        ALU_RESULT_SCANNER_zero_flag_xi,
    input  logic        ALU_RESULT_SCANNER_capture_xi,
    input  logic        ALU_RESULT_SCANNER_hold_xi,
    output logic [7:0]  ALU_RESULT_SCANNER_LED_xo,
    output logic [2:0]  ALU_RESULT_SCANNER_slot_xo,
    output logic        ALU_RESULT_SCANNER_captured_xo
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0] SLOT_LAST = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic             r_cap_s1, r_cap_s2, r_cap_s3;
    logic             r_hold_s1, r_hold_s2;
    state_t           r_state;
    logic [33:0]      r_snap;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_slot;
    logic             r_captured;
    logic             w_cap_edge;
    logic [7:0]       w_led;

    // Each sync chain resets to 0, so a button held through reset release reads as a fresh press.
    always_ff @(posedge ALU_RESULT_SCANNER_clk_xi or negedge ALU_RESULT_SCANNER_rst_n_xi) begin
        if (!ALU_RESULT_SCANNER_rst_n_xi) begin
            r_cap_s1  <= 1'b0;
            r_cap_s2  <= 1'b0;
            r_cap_s3  <= 1'b0;
            r_hold_s1 <= 1'b0;
            r_hold_s2 <= 1'b0;
        end else begin
            r_cap_s1  <= ALU_RESULT_SCANNER_capture_xi;
            r_cap_s2  <= r_cap_s1;
            r_cap_s3  <= r_cap_s2;
            r_hold_s1 <= ALU_RESULT_SCANNER_hold_xi;
            r_hold_s2 <= r_hold_s1;
        end
    end

    assign w_cap_edge = r_cap_s2 & ~r_cap_s3;

    always_ff @(posedge ALU_RESULT_SCANNER_clk_xi or negedge ALU_RESULT_SCANNER_rst_n_xi) begin
        if (!ALU_RESULT_SCANNER_rst_n_xi) begin
            r_state    <= ST_IDLE;
            r_snap     <= '0;
            r_cnt      <= '0;
            r_slot     <= '0;
            r_captured <= 1'b0;
        end else if (w_cap_edge) begin
            // A capture restarts the scan. It takes priority over the terminal count.
            // The hold level chosen here also covers a hold change in the same cycle.
            r_snap     <= {ALU_RESULT_SCANNER_overflow_flag_xi,
                           ALU_RESULT_SCANNER_zero_flag_xi,
                           ALU_RESULT_SCANNER_data_xi};
            r_cnt      <= '0;
            r_slot     <= '0;
            r_captured <= 1'b1;
            r_state    <= r_hold_s2 ? ST_HOLD : ST_SCAN;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_IDLE;
                ST_SCAN: begin
                    if (r_hold_s2) begin
                        r_state <= ST_HOLD;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt  <= '0;
                        r_slot <= (r_slot == SLOT_LAST) ? 3'd0 : r_slot + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!r_hold_s2) r_state <= ST_SCAN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_led = 8'h00;
        if (r_state != ST_IDLE) begin
            case (r_slot)
                3'd0:    w_led = r_snap[7:0];
                3'd1:    w_led = r_snap[15:8];
                3'd2:    w_led = r_snap[23:16];
                3'd3:    w_led = r_snap[31:24];
                3'd4:    w_led = {6'b0, r_snap[33:32]};
                default: w_led = 8'h00;
            endcase
        end
    end

    assign ALU_RESULT_SCANNER_LED_xo      = w_led;
    assign ALU_RESULT_SCANNER_slot_xo     = r_slot;
    assign ALU_RESULT_SCANNER_captured_xo = r_captured;

endmodule

// File: tb/tb_alu_result_scanner.sv
// Bench for alu_result_scanner with DWELL_CYCLES = 4.
// Stimulus queues the per-cycle LED/slot/captured values it expects; a negedge monitor compares them.
module tb_alu_result_scanner;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        of, zf, cap, hold;
    logic [7:0]  led;
    logic [2:0]  slot;
    logic        captured;

    alu_result_scanner #(.DWELL_CYCLES(DW)) dut (
        .ALU_RESULT_SCANNER_clk_xi           (clk),
        .ALU_RESULT_SCANNER_rst_n_xi         (rst_n),
        .ALU_RESULT_SCANNER_data_xi          (data),
        .ALU_RESULT_SCANNER_overflow_flag_xi (of),
        .ALU_RESULT_SCANNER_zero_flag_xi     (zf),
        .ALU_RESULT_SCANNER_capture_xi       (cap),
        .ALU_RESULT_SCANNER_hold_xi          (hold),
        .ALU_RESULT_SCANNER_LED_xo           (led),
        .ALU_RESULT_SCANNER_slot_xo          (slot),
        .ALU_RESULT_SCANNER_captured_xo      (captured)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] led;
        logic [2:0] slot;
        logic       cap;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %02h expected %02h", name, cyc, act, want);
    endtask

    task automatic push(input int at, input logic [7:0] l, input logic [2:0] s, input logic c);
        exp_t e;
        e.at = at; e.led = l; e.slot = s; e.cap = c;
        q.push_back(e);
    endtask

    // bytes = {slot4, slot3, slot2, slot1, slot0}; scan begins at slot 0 with a fresh counter
    task automatic push_scan(input int start, input int n, input logic [39:0] bytes);
        for (int k = 0; k < n; k++) begin
            int s;
            s = (k / DW) % 5;
            push(start + k, bytes[s*8 +: 8], 3'(s), 1'b1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at < cyc) begin
            check("missed_expectation", 8'(q[0].at), 8'(cyc));
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].at == cyc) begin
            exp_t e;
            e = q.pop_front();
            check("led", led, e.led);
            check("slot", {5'b0, slot}, {5'b0, e.slot});
            check("captured", {7'b0, captured}, {7'b0, e.cap});
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            step();
            t++;
        end
        check("queue_drained", 8'(q.size()), 8'd0);
    endtask

    initial begin
        int p, r;
        rst_n = 1'b0; cap = 1'b0; hold = 1'b0; data = '0; of = 1'b0; zf = 1'b0;
        #3;
        check("async_reset_led", led, 8'h00);
        check("async_reset_cap", {7'b0, captured}, 8'h00);
        repeat (2) step();
        rst_n = 1'b1;

        // Idle: no capture for 20 cycles
        p = cyc;
        for (int i = 1; i <= 20; i++) push(p + i, 8'h00, 3'd0, 1'b0);
        repeat (20) step();

        // Basic scan of 0x12345678; the capture takes effect on the third edge
        step();
        p = cyc;
        data = 32'h12345678; cap = 1'b1;
        push(p + 1, 8'h00, 3'd0, 1'b0);
        push(p + 2, 8'h00, 3'd0, 1'b0);
        push_scan(p + 3, 21, {8'h00, 8'h12, 8'h34, 8'h56, 8'h78});
        repeat (3) step();
        cap = 1'b0;
        repeat (22) step();

        // Flags only: slot 4 shows 0x03
        step();
        p = cyc;
        data = 32'h0; of = 1'b1; zf = 1'b1; cap = 1'b1;
        push_scan(p + 3, 20, {8'h03, 8'h00, 8'h00, 8'h00, 8'h00});
        repeat (2) step();
        cap = 1'b0;
        step();
        data = 32'hFFFF_FFFF; of = 1'b0; zf = 1'b0;
        repeat (22) step();

        // Hold during slot 2 with the counter at 1, held for 50 cycles
        step();
        p = cyc;
        data = 32'h12345678; cap = 1'b1;
        push_scan(p + 3, 8, {8'h00, 8'h12, 8'h34, 8'h56, 8'h78});
        for (int i = p + 11; i <= p + 65; i++) push(i, 8'h34, 3'd2, 1'b1);
        for (int i = p + 66; i <= p + 69; i++) push(i, 8'h12, 3'd3, 1'b1);
        repeat (2) step();
        cap = 1'b0;
        repeat (8) step();
        hold = 1'b1;
        repeat (50) step();
        hold = 1'b0;
        r = cyc;
        repeat (7) step();

        // The capture lands on the slot-3 terminal count; the capture wins
        data = 32'hAABBCCDD; cap = 1'b1;
        for (int i = r + 10; i <= r + 13; i++) push(i, 8'hDD, 3'd0, 1'b1);
        push(r + 14, 8'hCC, 3'd1, 1'b1);
        repeat (2) step();
        cap = 1'b0;
        drain();

        // Reset mid-scan, between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midscan_reset_led", led, 8'h00);
        check("midscan_reset_slot", {5'b0, slot}, 8'h00);
        check("midscan_reset_cap", {7'b0, captured}, 8'h00);
        repeat (2) step();
        rst_n = 1'b1;
        p = cyc;
        for (int i = 1; i <= 8; i++) push(p + i, 8'h00, 3'd0, 1'b0);
        repeat (8) step();

        // Capture held high through reset release captures on the third edge
        rst_n = 1'b0;
        data = 32'h11223344; cap = 1'b1;
        step();
        rst_n = 1'b1;
        p = cyc;
        push(p + 1, 8'h00, 3'd0, 1'b0);
        push(p + 2, 8'h00, 3'd0, 1'b0);
        push_scan(p + 3, 5, {8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
        repeat (10) step();
        cap = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_result_scanner.md
ALU_RESULT_SCANNER -- requirements
Module: ALU_RESULT_SCANNER

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50000000: clock cycles each byte stays on the LEDs; legal range >= 2.
REQ-002 SHALL have port ALU_RESULT_SCANNER_clk_xi, input, 1: the single clock; all flops on its rising edge.
REQ-003 SHALL have port ALU_RESULT_SCANNER_rst_n_xi, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port ALU_RESULT_SCANNER_data_xi, input, 32: ALU result F.
REQ-005 SHALL have port ALU_RESULT_SCANNER_overflow_flag_xi, input, 1: ALU overflow flag.
REQ-006 SHALL have port ALU_RESULT_SCANNER_zero_flag_xi, input, 1: ALU zero flag.
REQ-007 SHALL have port ALU_RESULT_SCANNER_capture_xi, input, 1: asynchronous capture button (level).
REQ-008 SHALL have port ALU_RESULT_SCANNER_hold_xi, input, 1: asynchronous freeze switch (level).
REQ-009 SHALL have port ALU_RESULT_SCANNER_LED_xo, output, 8: displayed byte.
REQ-010 SHALL have port ALU_RESULT_SCANNER_slot_xo, output, 3: index of the displayed slot, 0-4.
REQ-011 SHALL have port ALU_RESULT_SCANNER_captured_xo, output, 1: high once any snapshot has been taken.

Function
REQ-012 SHALL pass capture_xi and hold_xi each through a 2-flop synchronizer; capture additionally through a third flop, with edge = sync2 & ~sync3.
REQ-013 SHALL load snapshot {OF, ZF, F} on the clock edge at which edge is true; capture_xi rising before clock edge 1 loads at edge 3.
REQ-014 SHALL implement states IDLE, SCAN and HOLD.
REQ-015 IDLE: LED_xo = 0x00, slot_xo = 0, dwell counter = 0.
REQ-016 IDLE -> SCAN on capture edge when synchronized hold = 0; IDLE -> HOLD on capture edge when it = 1.
REQ-017 SCAN: dwell counter increments each cycle from 0 to DWELL_CYCLES-1; at terminal count, counter -> 0 and slot advances.
REQ-018 Slot sequence SHALL be 0,1,2,3,4,0,... (wraps from 4 to 0).
REQ-019 Slot contents SHALL be: 0 = F[7:0]; 1 = F[15:8]; 2 = F[23:16]; 3 = F[31:24]; 4 = {6'b0, OF, ZF}.
REQ-020 SCAN -> HOLD when synchronized hold = 1; counter and slot SHALL be frozen while in HOLD.
REQ-021 HOLD -> SCAN when synchronized hold = 0; counting SHALL resume from the frozen counter value.
REQ-022 A capture edge in SCAN or HOLD SHALL reload the snapshot, set slot = 0 and counter = 0, and leave the state unchanged.
REQ-023 Capture edge coincident with terminal count: capture wins (slot 0, counter 0).
REQ-024 Capture edge coincident with a hold transition: both SHALL take effect in the same cycle.
REQ-025 LED_xo, slot_xo and captured_xo SHALL be decoded from registers only, with no combinational path from any input.
REQ-026 In SCAN and HOLD, LED_xo SHALL equal the snapshot byte selected by the slot; it SHALL update in the same cycle the slot or snapshot register changes.
REQ-027 captured_xo SHALL be set on the first capture edge and stay set until reset.
REQ-028 The counter width SHALL be ceil(log2(DWELL_CYCLES)); the counter SHALL never exceed DWELL_CYCLES-1.

Reset
REQ-029 While rst_n_xi = 0, without any clock, the block SHALL force: all synchronizer flops = 0, state = IDLE, snapshot = 0, counter = 0, slot = 0, LED_xo = 0x00, captured_xo = 0.
REQ-030 A reset asserted mid-scan SHALL abort immediately, and the snapshot SHALL be lost.
REQ-031 If capture_xi is held high through reset release, the block SHALL treat it as a rising edge and capture at the third clock edge after release.

Verification (DWELL_CYCLES = 4)
REQ-032 Reset, then 20 cycles with no capture -> LED_xo = 0x00, slot_xo = 0, captured_xo = 0 throughout.
REQ-033 F = 0x12345678, OF = 0, ZF = 0, 3-cycle capture pulse -> from edge 3: LED 0x78 x4, 0x56 x4, 0x34 x4, 0x12 x4, 0x00 x4, then 0x78 again; captured_xo = 1.
REQ-034 F = 0x00000000, OF = 1, ZF = 1, capture -> slot 4 shows LED 0x03; slots 0-3 show 0x00.
REQ-035 Hold asserted during slot 2 after 1 dwell cycle -> LED stays 0x34 for 50 cycles; after release, 0x34 remains for the 3 remaining cycles (plus sync latency) before 0x12 appears.
REQ-036 Capture of F = 0xAABBCCDD timed to coincide with terminal count in slot 3 -> next cycle slot_xo = 0, LED 0xDD, held for 4 cycles.
REQ-037 rst_n_xi pulled low mid-scan between clock edges -> LED_xo = 0x00, slot_xo = 0, captured_xo = 0 immediately; after release the block remains in IDLE until a new capture.
